// File: rtl/apb_master_bridge.sv
// APB master bridge: single-command valid/ready port to an APB
// SETUP/ACCESS sequence, with a response pulse and an ACCESS timeout.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        err_count,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TO_L = (CW+1)'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]        err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW:0]       cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

  // Next-state, APB drive and response decode
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          if (!pwrite_q) rsp_rdata_d = PRDATA;
        end else if (TIMEOUT != 0 && cnt_inc == TO_L) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          cnt_d       = '0;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // Register all outputs and state; reset aborts any transfer
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a tiny APB memory
// slave used for the back-to-back sequence.
module tb_apb_master_bridge;

  logic        clk;
  logic        RESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_count;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  logic        slave_en;
  logic        pready_r;
  logic [31:0] prdata_r;
  logic [31:0] mem [0:15];

  int checks;
  int failures;
  int viol;

  apb_master_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .err_count(err_count),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign PREADY = slave_en ? 1'b1 : pready_r;
  assign PRDATA = slave_en ? mem[PADDR[5:2]] : prdata_r;

  always @(posedge clk) begin
    if (slave_en && PSELx && PENABLE && PWRITE)
      mem[PADDR[5:2]] <= PWDATA;
  end

  always @(negedge clk) begin
    if (!RESET && PSELx && cmd_ready) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    viol      = 0;
    slave_en  = 1'b0;
    pready_r  = 1'b0;
    prdata_r  = 32'h0;
    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("rst_psel", {31'd0, PSELx}, 32'd0);
    chk("rst_pen", {31'd0, PENABLE}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_errc", {24'd0, err_count}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);

    // zero-wait write, PREADY stale-high through IDLE/SETUP
    pready_r  = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4;
    cmd_wdata = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    chk("w_c1_psel", {31'd0, PSELx}, 32'd1);
    chk("w_c1_pen", {31'd0, PENABLE}, 32'd0);
    chk("w_c1_paddr", PADDR, 32'h4);
    chk("w_c1_pwdata", PWDATA, 32'hDEADBEEF);
    chk("w_c1_pwrite", {31'd0, PWRITE}, 32'd1);
    chk("w_c1_ready", {31'd0, cmd_ready}, 32'd0);
    chk("w_c1_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("w_c2_pen", {31'd0, PENABLE}, 32'd1);
    chk("w_c2_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("w_c3_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("w_c3_err", {31'd0, rsp_err}, 32'd0);
    chk("w_c3_psel", {31'd0, PSELx}, 32'd0);
    chk("w_c3_ready", {31'd0, cmd_ready}, 32'd1);
    chk("w_c3_rdata", rsp_rdata, 32'h0);
    tick();
    chk("w_c4_rsp", {31'd0, rsp_valid}, 32'd0);

    // read with two wait states
    pready_r  = 1'b0;
    prdata_r  = 32'h0BAD0BAD;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4;
    cmd_wdata = 32'h55555555;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'h99;
    chk("r_c1_pwdata", PWDATA, 32'h0);
    chk("r_c1_pwrite", {31'd0, PWRITE}, 32'd0);
    tick();
    chk("r_c2_pen", {31'd0, PENABLE}, 32'd1);
    tick();
    chk("r_c3_pen", {31'd0, PENABLE}, 32'd1);
    chk("r_c3_paddr", PADDR, 32'h4);
    chk("r_c3_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("r_c4_pen", {31'd0, PENABLE}, 32'd1);
    chk("r_c4_paddr", PADDR, 32'h4);
    pready_r = 1'b1;
    prdata_r = 32'hDEADBEEF;
    tick();
    pready_r = 1'b0;
    chk("r_c5_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("r_c5_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("r_c5_err", {31'd0, rsp_err}, 32'd0);

    // timeout with PREADY held low
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h10;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("t_c5_pen", {31'd0, PENABLE}, 32'd1);
    chk("t_c5_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t_c6_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("t_c6_err", {31'd0, rsp_err}, 32'd1);
    chk("t_c6_rdata", rsp_rdata, 32'h0);
    chk("t_c6_errc", {24'd0, err_count}, 32'd1);
    chk("t_c6_psel", {31'd0, PSELx}, 32'd0);
    for (int i = 0; i < 254; i++) begin
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (5) tick();
    end
    chk("t_errc_255", {24'd0, err_count}, 32'd255);
    for (int i = 0; i < 45; i++) begin
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (5) tick();
    end
    chk("t_errc_sat", {24'd0, err_count}, 32'd255);
    chk("t_last_err", {31'd0, rsp_err}, 32'd1);

    // back-to-back against memory slave
    slave_en  = 1'b1;
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h8;
    cmd_wdata = 32'h12345678;
    tick();
    cmd_write = 1'b0;
    cmd_wdata = 32'h0;
    chk("b_c1_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    tick();
    chk("b_c3_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b_c3_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b_c4_psel", {31'd0, PSELx}, 32'd1);
    chk("b_c4_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("b_c4_paddr", PADDR, 32'h8);
    tick();
    tick();
    chk("b_c6_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b_c6_rdata", rsp_rdata, 32'h12345678);
    slave_en = 1'b0;

    // reset during ACCESS with PREADY low
    pready_r  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h20;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("x_pre_pen", {31'd0, PENABLE}, 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("x_psel", {31'd0, PSELx}, 32'd0);
    chk("x_pen", {31'd0, PENABLE}, 32'd0);
    chk("x_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("x_ready", {31'd0, cmd_ready}, 32'd1);
    chk("x_errc", {24'd0, err_count}, 32'd0);
    tick();
    chk("x_rsp2", {31'd0, rsp_valid}, 32'd0);

    chk("psel_vs_ready", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
